fifo_drain_reader: RTL and testbench

- Consumer end of the 4-channel FIFO router: reads the four output FIFOs (fifo4..fifo7), which the router fills.
- Pops with a round-robin pointer and captures the returned words one cycle later.
- Checks each word's destination field, keeps a per-channel packet count, and answers req/idx count queries with counter_out.
- Replaces bench-driven pops for integration and gate-level runs.

---
 rtl/fifo_drain_reader_pkg.sv | 46 ++++
 rtl/fifo_drain_reader_if.sv | 22 ++
 rtl/fifo_drain_reader_sat_counter.sv | 30 +++
 rtl/fifo_drain_reader.sv | 148 ++++++++++++++
 tb/tb_fifo_drain_reader.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_drain_reader_pkg.sv
// ============================================================================
// Module   : fdr_pkg
// Brief    : Shared types, defaults and round-robin pick helper for the reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fdr_pkg;

  localparam int c_data_w = 10;
  localparam int c_num_ch = 4;
  localparam int c_cnt_w  = 5;
  localparam int c_ch_w   = 2;
  // Destination field is the top c_dest_w bits of each word.
  localparam int c_dest_w = 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic              found;
    logic [c_ch_w-1:0] ch;
  } pick_t;

  // Walks downward so the channel nearest the pointer is the one kept.
  function automatic pick_t rr_pick(input logic [c_num_ch-1:0] empty,
                                    input logic [c_ch_w-1:0]   ptr);
    pick_t             res;
    logic [c_ch_w-1:0] cand;
    res = '0;
    for (int i = c_num_ch - 1; i >= 0; i--) begin
      cand = ptr + c_ch_w'(i);
      if (!empty[cand]) begin
        res.found = 1'b1;
        res.ch    = cand;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_drain_reader_if.sv
// ============================================================================
// Module   : fifo_drain_reader_if
// Brief    : Read-side bundle between the output FIFOs and the drain reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_drain_reader_if
  import fdr_pkg::*;
#(
  parameter int NUM_CH = c_num_ch,
  parameter int DATA_W = c_data_w
);
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        pop;

  modport master (input fifo_empty, input fifo_data, output pop);
  modport slave  (output fifo_empty, output fifo_data, input pop);
endinterface

`default_nettype wire

// File: rtl/fifo_drain_reader_sat_counter.sv
// ============================================================================
// Module   : fdr_sat_counter
// Brief    : Saturating up-counter with synchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fdr_sat_counter #(
  parameter int CNT_W = 5
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_drain_reader.sv
// ============================================================================
// Module   : fifo_drain_reader
// Brief    : Round-robin consumer of the router output FIFOs with per-channel
//            packet counts; DEST_CHECK_EN adds sticky destination-error flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_drain_reader
  import fdr_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int NUM_CH = c_num_ch,
  parameter int CNT_W  = c_cnt_w
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                init,
  input  wire logic                enable,
  fifo_drain_reader_if.master      fifo,
  output logic      [DATA_W-1:0]   data_out,
  output logic                     data_valid,
  output logic      [c_ch_w-1:0]   data_ch,
  input  wire logic                req,
  input  wire logic [c_ch_w-1:0]   idx,
  output logic      [CNT_W-1:0]    counter_out,
  output logic                     counter_valid,
  output logic                     idle,
  output logic      [NUM_CH-1:0]   err
);

  state_t              r_state;
  logic [c_ch_w-1:0]   r_ptr;
  logic [NUM_CH-1:0]   r_pop;

  logic [NUM_CH-1:0]   w_eff_empty;
  pick_t               w_pick;
  logic [NUM_CH-1:0]   w_pick_onehot;
  logic [NUM_CH-1:0]   w_cap;
  logic [c_ch_w-1:0]   w_cap_ch;
  logic [DATA_W-1:0]   w_cap_word;
  logic [CNT_W-1:0]    w_count [NUM_CH];

  // A channel popped last cycle still shows its pre-pop empty flag.
  assign w_eff_empty   = fifo.fifo_empty | r_pop;
  assign w_pick        = rr_pick(w_eff_empty, r_ptr);
  assign w_pick_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << w_pick.ch;
  assign w_cap         = r_pop & {NUM_CH{~init}};
  assign w_cap_word    = fifo.fifo_data[w_cap_ch*DATA_W +: DATA_W];
  assign fifo.pop      = r_pop;

  always_comb begin
    w_cap_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_pop[c]) w_cap_ch = c_ch_w'(c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_INIT;
      r_ptr         <= '0;
      r_pop         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      data_ch       <= '0;
      counter_out   <= '0;
      counter_valid <= 1'b0;
      idle          <= 1'b0;
    end else begin
      r_pop         <= '0;
      data_valid    <= 1'b0;
      counter_valid <= req;

      if (|w_cap) begin
        data_out   <= w_cap_word;
        data_ch    <= w_cap_ch;
        data_valid <= 1'b1;
      end

      if (req) begin
        counter_out <= (init || (r_state == ST_INIT)) ? '0 : w_count[idx];
      end

      if (init) begin
        r_state <= ST_INIT;
        idle    <= 1'b0;
      end else begin
        case (r_state)
          ST_INIT: begin
            r_state <= ST_IDLE;
            idle    <= 1'b1;
          end
          ST_IDLE: begin
            if (enable && !(&fifo.fifo_empty)) begin
              r_state <= ST_ACTIVE;
              idle    <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (enable && w_pick.found) begin
              r_pop <= w_pick_onehot;
              r_ptr <= w_pick.ch + c_ch_w'(1);
            end else if ((&fifo.fifo_empty) && (r_pop == '0)) begin
              r_state <= ST_IDLE;
              idle    <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_INIT;
            idle    <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    fdr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (init),
      .inc   (w_cap[g]),
      .count (w_count[g])
    );
  end

`ifdef DEST_CHECK_EN
  logic [NUM_CH-1:0] r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= '0;
    end else if (init) begin
      r_err <= '0;
    end else if ((|w_cap) && (w_cap_word[DATA_W-1 -: c_dest_w] != w_cap_ch)) begin
      r_err[w_cap_ch] <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_reader.sv
// ============================================================================
// Module   : tb_fifo_drain_reader
// Brief    : Directed self-checking bench with a show-ahead FIFO model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_drain_reader;

  logic       clk;
  logic       reset;
  logic       init;
  logic       enable;
  logic       req;
  logic [1:0] idx;
  logic [9:0] data_out;
  logic       data_valid;
  logic [1:0] data_ch;
  logic [4:0] counter_out;
  logic       counter_valid;
  logic       idle;
  logic [3:0] err;

  fifo_drain_reader_if ifc ();

  fifo_drain_reader dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .enable        (enable),
    .fifo          (ifc.master),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ch       (data_ch),
    .req           (req),
    .idx           (idx),
    .counter_out   (counter_out),
    .counter_valid (counter_valid),
    .idle          (idle),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0] fq [4][$];
  logic [3:0] pend = 4'h0;
  int         cyc = 0;
  int         multi_pop = 0;
  int         pop_ch [$];
  int         pop_cy [$];
  int         val_ch [$];
  int         val_dat [$];
  int         val_cy [$];

  // Show-ahead FIFO: a pop seen during cycle N retires the head after edge N+1.
  always @(negedge clk) begin
    cyc++;
    if (ifc.pop != 4'h0) begin
      if ($countones(ifc.pop) != 1) multi_pop++;
      for (int c = 0; c < 4; c++) begin
        if (ifc.pop[c]) begin
          pop_ch.push_back(c);
          pop_cy.push_back(cyc);
        end
      end
    end
    if (data_valid) begin
      val_ch.push_back(int'(data_ch));
      val_dat.push_back(int'(data_out));
      val_cy.push_back(cyc);
    end
    for (int c = 0; c < 4; c++) begin
      if (pend[c] && fq[c].size() > 0) void'(fq[c].pop_front());
    end
    pend = ifc.pop;
    for (int c = 0; c < 4; c++) begin
      ifc.fifo_empty[c]          = (fq[c].size() == 0);
      ifc.fifo_data[c*10 +: 10]  = (fq[c].size() > 0) ? fq[c][0] : 10'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input logic [1:0] q, input logic [4:0] exp, input string tag);
    req = 1'b1;
    idx = q;
    step();
    chk({tag, "_cv"}, 32'(counter_valid), 32'd1);
    chk({tag, "_co"}, 32'(counter_out), 32'(exp));
    req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (!idle && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_idle_timeout"}, 32'(idle), 32'd1);
  endtask

  task automatic clear_logs();
    pop_ch.delete();
    pop_cy.delete();
    val_ch.delete();
    val_dat.delete();
    val_cy.delete();
  endtask

  function automatic logic [9:0] word_of(input int ch, input int k);
    return 10'(ch * 256 + ch * 16 + k + 1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_bad;
    int ch_bad;
    int k;

    reset          = 1'b0;
    init           = 1'b1;
    enable         = 1'b0;
    req            = 1'b0;
    idx            = 2'd0;
    ifc.fifo_empty = 4'hF;
    ifc.fifo_data  = '0;

    // Reset and init sequencing
    repeat (4) step();
    chk("rst_pop", 32'(ifc.pop), 32'h0);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_idle", 32'(idle), 32'h0);
    chk("rst_cv", 32'(counter_valid), 32'h0);
    chk("rst_co", 32'(counter_out), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b1;
    repeat (3) begin
      step();
      chk("init_pop", 32'(ifc.pop), 32'h0);
      chk("init_idle", 32'(idle), 32'h0);
    end
    init = 1'b0;
    step();
    chk("idle_after_init", 32'(idle), 32'd1);
    query(2'd2, 5'd0, "q_init_idx2");
    step();
    chk("cv_drop", 32'(counter_valid), 32'd0);
    chk("co_hold", 32'(counter_out), 32'd0);

    // Two words in every FIFO: strict round robin
    clear_logs();
    for (int c = 0; c < 4; c++) begin
      fq[c].push_back(word_of(c, 0));
      fq[c].push_back(word_of(c, 1));
    end
    enable = 1'b1;
    repeat (2) step();
    wait_idle(40, "rr");
    chk("rr_pop_cnt", 32'(pop_ch.size()), 32'd8);
    chk("rr_val_cnt", 32'(val_ch.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_ch.size() && i < val_ch.size()) begin
        chk($sformatf("rr_pop_ch%0d", i), 32'(pop_ch[i]), 32'(i % 4));
        chk($sformatf("rr_val_ch%0d", i), 32'(val_ch[i]), 32'(i % 4));
        chk($sformatf("rr_val_dat%0d", i), 32'(val_dat[i]), 32'(word_of(i % 4, i / 4)));
        chk($sformatf("rr_latency%0d", i), 32'(val_cy[i] - pop_cy[i]), 32'd1);
      end
    end
    chk("rr_onehot", 32'(multi_pop), 32'd0);
    for (int c = 0; c < 4; c++) query(2'(c), 5'd2, $sformatf("rr_cnt%0d", c));

    // Clear with init, then saturate channel 2
    init = 1'b1;
    step();
    chk("init2_idle", 32'(idle), 32'd0);
    init = 1'b0;
    step();
    chk("init2_idle_back", 32'(idle), 32'd1);
    query(2'd2, 5'd0, "cleared_cnt2");
    clear_logs();
    for (int i = 0; i < 30; i++) fq[2].push_back(10'(2 * 256 + i));
    repeat (2) step();
    wait_idle(120, "sat30");
    chk("sat30_val_cnt", 32'(val_ch.size()), 32'd30);
    gap_bad = 0;
    ch_bad  = 0;
    for (int i = 0; i < pop_ch.size(); i++) begin
      if (pop_ch[i] != 2) ch_bad++;
      if (i > 0 && (pop_cy[i] - pop_cy[i-1]) < 2) gap_bad++;
    end
    chk("sat_only_ch2", 32'(ch_bad), 32'd0);
    chk("sat_pop_spacing", 32'(gap_bad), 32'd0);
    query(2'd2, 5'd30, "cnt2_30");
    for (int i = 30; i < 40; i++) fq[2].push_back(10'(2 * 256 + i));
    repeat (2) step();
    wait_idle(60, "sat40");
    chk("sat40_val_cnt", 32'(val_ch.size()), 32'd40);
    query(2'd2, 5'd31, "cnt2_sat");
    query(2'd0, 5'd0, "cnt0_untouched");
    step();
    chk("co_hold_sat", 32'(counter_out), 32'd0);
    chk("cv_low_sat", 32'(counter_valid), 32'd0);

    // Wrong destination on channel 1
    clear_logs();
    fq[1].push_back(10'h3A5);
    repeat (2) step();
    wait_idle(20, "dest");
    chk("dest_dat", 32'(data_out), 32'h3A5);
    chk("dest_ch", 32'(data_ch), 32'd1);
`ifdef DEST_CHECK_EN
    chk("dest_err", 32'(err), 32'b0010);
    step();
    chk("dest_err_sticky", 32'(err), 32'b0010);
`else
    chk("dest_err_off", 32'(err), 32'h0);
`endif
    query(2'd1, 5'd1, "dest_cnt1");
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    chk("dest_err_clr", 32'(err), 32'h0);
    query(2'd1, 5'd0, "dest_cnt1_clr");

    // Enable drop right after pop[0]
    clear_logs();
    fq[0].push_back(10'h055);
    fq[1].push_back(10'h1AA);
    k = 0;
    step();
    while (!ifc.pop[0] && k < 10) begin
      step();
      k++;
    end
    enable = 1'b0;
    chk("en_pop0", 32'(ifc.pop), 32'b0001);
    step();
    chk("en_cap_dv", 32'(data_valid), 32'd1);
    chk("en_cap_ch", 32'(data_ch), 32'd0);
    chk("en_cap_dat", 32'(data_out), 32'h055);
    chk("en_no_pop", 32'(ifc.pop), 32'h0);
    repeat (4) step();
    chk("en_frozen_pops", 32'(pop_ch.size()), 32'd1);
    chk("en_not_idle", 32'(idle), 32'd0);
    query(2'd0, 5'd1, "en_cnt0");
    enable = 1'b1;
    step();
    chk("en_resume_ch1", 32'(ifc.pop), 32'b0010);
    wait_idle(20, "en");
    chk("en_last_dat", 32'(data_out), 32'h1AA);

    // Reset while a capture is pending
    fq[3].push_back(10'h3C1);
    fq[3].push_back(10'h3C2);
    k = 0;
    step();
    while (!ifc.pop[3] && k < 10) begin
      step();
      k++;
    end
    chk("rr_reached_ch3", 32'(ifc.pop), 32'b1000);
    reset = 1'b0;
    enable = 1'b0;
    #1;
    clear_logs();
    chk("mid_rst_pop", 32'(ifc.pop), 32'h0);
    chk("mid_rst_dv", 32'(data_valid), 32'h0);
    chk("mid_rst_co", 32'(counter_out), 32'h0);
    chk("mid_rst_idle", 32'(idle), 32'h0);
    step();
    chk("mid_rst_dv_edge", 32'(data_valid), 32'h0);
    reset = 1'b1;
    repeat (3) step();
    chk("post_rst_no_cap", 32'(val_ch.size()), 32'd0);
    chk("post_rst_idle", 32'(idle), 32'd1);
    query(2'd3, 5'd0, "post_rst_cnt3");
    query(2'd0, 5'd0, "post_rst_cnt0");
    chk("post_rst_no_pop", 32'(pop_ch.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
